// File: rtl/nx1_vram_arb_pkg.sv
// nx1_vram_pkg: region codes, arbiter state encoding and GRAM plane priority shared by the VRAM arbiter
package nx1_vram_pkg;

    localparam logic [2:0] REG_ATTR  = 3'd0;
    localparam logic [2:0] REG_TEXT  = 3'd1;
    localparam logic [2:0] REG_KANJI = 3'd2;
    localparam logic [2:0] REG_B     = 3'd3;
    localparam logic [2:0] REG_R     = 3'd4;
    localparam logic [2:0] REG_G     = 3'd5;

    // Plane mask bit positions; a lower bit is serviced first (B, then R, then G).
    localparam int PL_B = 0;
    localparam int PL_R = 1;
    localparam int PL_G = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_DSP, ST_CPU, ST_CPU_NXT} state_t;

    function automatic logic [2:0] plane_region(input logic [2:0] mask);
        return mask[PL_B] ? REG_B : mask[PL_R] ? REG_R : REG_G;
    endfunction

endpackage

// File: rtl/nx1_vram_arb_if.sv
// nx1_vram_arb_if: CPU bus, display fetch and SRAM port signals of the VRAM arbiter
interface nx1_vram_arb_if;

    logic        I_RD_n, I_WR_n;
    logic [13:0] I_A;
    logic [7:0]  I_D;
    logic        I_ATTR_CS, I_TEXT_CS, I_KANJI_CS, I_GRB_CS, I_GRR_CS, I_GRG_CS;
    logic [7:0]  O_CPU_D;
    logic        O_WAIT_n;
    logic        I_DSP_REQ;
    logic [16:0] I_DSP_A;
    logic        O_DSP_ACK;
    logic [7:0]  O_DSP_D;
    logic        O_MEM_CE, O_MEM_WE;
    logic [16:0] O_MEM_A;
    logic [7:0]  O_MEM_D;
    logic [7:0]  I_MEM_Q;

    modport master (
        output I_RD_n, I_WR_n, I_A, I_D, I_ATTR_CS, I_TEXT_CS, I_KANJI_CS,
               I_GRB_CS, I_GRR_CS, I_GRG_CS, I_DSP_REQ, I_DSP_A, I_MEM_Q,
        input  O_CPU_D, O_WAIT_n, O_DSP_ACK, O_DSP_D, O_MEM_CE, O_MEM_WE, O_MEM_A, O_MEM_D
    );

    modport slave (
        input  I_RD_n, I_WR_n, I_A, I_D, I_ATTR_CS, I_TEXT_CS, I_KANJI_CS,
               I_GRB_CS, I_GRR_CS, I_GRG_CS, I_DSP_REQ, I_DSP_A, I_MEM_Q,
        output O_CPU_D, O_WAIT_n, O_DSP_ACK, O_DSP_D, O_MEM_CE, O_MEM_WE, O_MEM_A, O_MEM_D
    );

endinterface

// File: rtl/nx1_vram_arb_seq.sv
// nx1_vram_seq: MEM_CYC-long SRAM access timer producing CE/WE and the last-cycle sample strobe
module nx1_vram_seq #(
    parameter int MEM_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_act,
    input  logic i_we,
    output logic o_ce,
    output logic o_we,
    output logic o_last
);

    logic [2:0] r_cnt;

    // Count clocks of the running access; restart from zero once it ends or the bus idles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= 3'd0;
        else          r_cnt <= (i_act && !o_last) ? r_cnt + 3'd1 : 3'd0;
    end

    // Strobes decode straight from the access state so a reset drops them without waiting for a clock.
    always_comb begin
        o_ce   = i_act;
        o_we   = i_act & i_we;
        o_last = i_act && (r_cnt == 3'(MEM_CYC - 1));
    end

endmodule

// File: rtl/nx1_vram_arb.sv
// nx1_vram_arb: shares one VRAM SRAM port between Z80 I/O VRAM cycles and CRTC display fetch.
// Define NX1_DAM_MULTIWRITE_EN to write every selected GRAM plane of a DAM write in turn.
module nx1_vram_arb #(
    parameter int MEM_CYC     = 2,
    parameter int STARVE_MAX  = 4,
    parameter int def_X1TURBO = 0
) (
    input  logic            I_CLK,
    input  logic            I_RESET_n,
    nx1_vram_arb_if.slave   bus
);
    import nx1_vram_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 2);

    state_t        r_state, w_nxt;
    logic [SW-1:0] r_starve;
    logic          r_cpu_done, r_we, r_dsp_ack;
    logic [7:0]    r_cpu_d, r_dsp_d, r_mem_d;
    logic [16:0]   r_mem_a;
    logic [2:0]    w_gmask, w_region;
    logic [13:0]   w_off;
    logic          w_kanji, w_cpu_req, w_pend, w_dsp_go, w_more, w_last, w_act, w_we_req, w_ce, w_we;
`ifdef NX1_DAM_MULTIWRITE_EN
    logic [2:0]    r_mask, w_nmask;
`endif

    assign w_act    = (r_state == ST_DSP) || (r_state == ST_CPU);
    assign w_we_req = (r_state == ST_CPU) && r_we;

    nx1_vram_seq #(.MEM_CYC(MEM_CYC)) u_seq (
        .i_clk   (I_CLK),
        .i_rst_n (I_RESET_n),
        .i_act   (w_act),
        .i_we    (w_we_req),
        .o_ce    (w_ce),
        .o_we    (w_we),
        .o_last  (w_last)
    );

    // Decode the CPU request and its SRAM address, then choose the next arbiter state.
    always_comb begin
        w_kanji   = bus.I_KANJI_CS && (def_X1TURBO != 0);
        w_cpu_req = (bus.I_ATTR_CS | bus.I_TEXT_CS | w_kanji | bus.I_GRB_CS | bus.I_GRR_CS | bus.I_GRG_CS)
                    & (~bus.I_RD_n | ~bus.I_WR_n);
        w_pend    = w_cpu_req & ~r_cpu_done;
        w_dsp_go  = bus.I_DSP_REQ && (!w_pend || (r_starve < SW'(STARVE_MAX)));
        w_gmask       = 3'b000;
        w_gmask[PL_B] = bus.I_GRB_CS;
        w_gmask[PL_R] = bus.I_GRR_CS;
        w_gmask[PL_G] = bus.I_GRG_CS;
        w_region  = bus.I_ATTR_CS ? REG_ATTR : bus.I_TEXT_CS ? REG_TEXT : w_kanji ? REG_KANJI : plane_region(w_gmask);
        w_off     = (w_region > REG_KANJI) ? bus.I_A : {3'b000, bus.I_A[10:0]};
`ifdef NX1_DAM_MULTIWRITE_EN
        w_nmask   = r_mask & (r_mask - 3'd1);
        w_more    = r_we && w_cpu_req && (w_nmask != 3'd0);
`else
        w_more    = 1'b0;
`endif
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:    w_nxt = w_dsp_go ? ST_DSP : w_pend ? ST_CPU : ST_IDLE;
            ST_DSP:     w_nxt = w_last ? ST_IDLE : ST_DSP;
            ST_CPU:     w_nxt = !w_last ? ST_CPU : w_more ? ST_CPU_NXT : ST_IDLE;
`ifdef NX1_DAM_MULTIWRITE_EN
            ST_CPU_NXT: w_nxt = ST_CPU;
`endif
            default:    w_nxt = ST_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) r_state <= ST_IDLE;
        else            r_state <= w_nxt;
    end

    // Latch grant parameters, capture read data and track CPU completion and display starvation.
    always_ff @(posedge I_CLK or negedge I_RESET_n) begin
        if (!I_RESET_n) begin
            r_starve   <= '0;
            r_cpu_done <= 1'b0;
            r_we       <= 1'b0;
            r_dsp_ack  <= 1'b0;
            r_cpu_d    <= 8'hFF;
            r_dsp_d    <= 8'h00;
            r_mem_d    <= 8'h00;
            r_mem_a    <= 17'h0;
`ifdef NX1_DAM_MULTIWRITE_EN
            r_mask     <= 3'b000;
`endif
        end else begin
            r_dsp_ack <= (r_state == ST_DSP) && w_last;
            if ((r_state == ST_DSP) && w_last) r_dsp_d <= bus.I_MEM_Q;
            if ((r_state == ST_CPU) && w_last && !r_we) r_cpu_d <= bus.I_MEM_Q;
            if ((r_state == ST_IDLE) && w_dsp_go) r_mem_a <= bus.I_DSP_A;
            else if ((r_state == ST_IDLE) && w_pend) begin
                r_mem_a <= {w_region, w_off};
                r_mem_d <= bus.I_D;
                r_we    <= ~bus.I_WR_n;
`ifdef NX1_DAM_MULTIWRITE_EN
                r_mask  <= w_gmask;
            end else if (r_state == ST_CPU_NXT) begin
                r_mask         <= w_nmask;
                r_mem_a[16:14] <= plane_region(w_nmask);
`endif
            end
            r_cpu_done <= w_cpu_req && (r_cpu_done || ((r_state == ST_CPU) && w_last && !w_more));
            r_starve   <= !w_pend ? '0 : (r_state != ST_IDLE) ? r_starve : w_dsp_go ? r_starve + 1'b1 : '0;
        end
    end

    assign bus.O_MEM_CE  = w_ce;
    assign bus.O_MEM_WE  = w_we;
    assign bus.O_MEM_A   = r_mem_a;
    assign bus.O_MEM_D   = r_mem_d;
    assign bus.O_CPU_D   = r_cpu_d;
    assign bus.O_DSP_D   = r_dsp_d;
    assign bus.O_DSP_ACK = r_dsp_ack;
    assign bus.O_WAIT_n  = ~(I_RESET_n & w_cpu_req & ~r_cpu_done);

endmodule

// File: doc/nx1_vram_arb.md
Name: nx1_vram_arb

Overview:
- Arbitrates one shared single-port VRAM between CPU I/O-mapped VRAM cycles and CRTC display fetch.
- CPU cycles are recognised from the address-decoder chip selects: ATTR/TEXT/KANJI/GRB/GRR/GRG.
- Stretches the Z80 cycle with WAIT until the CPU access completes.
- Sits between the address decoder / CPU bus and the external VRAM SRAM port.

Parameters:
- MEM_CYC, 2: SRAM access length in clocks (1..7); CE held for MEM_CYC clocks, read data sampled on the last one.
- STARVE_MAX, 4: consecutive display grants allowed while a CPU request is pending; the next grant then goes to the CPU.
- def_X1TURBO, 0: 0 forces KANJI_CS to be ignored; 1 honours it.

Ports:
- I_CLK  in  1  system clock.
- I_RESET_n  in  1  asynchronous active-low reset.
- I_RD_n, I_WR_n  in  1 each  Z80 strobes.
- I_A  in  14  CPU address bits 13:0.
- I_D  in  8  CPU write data.
- I_ATTR_CS, I_TEXT_CS, I_KANJI_CS  in  1 each  text-side VRAM selects.
- I_GRB_CS, I_GRR_CS, I_GRG_CS  in  1 each  GRAM plane selects; more than one may be high in DAM.
- O_CPU_D  out  8  CPU read data, held until the next CPU read completes.
- O_WAIT_n  out  1  Z80 WAIT.
- I_DSP_REQ  in  1  display fetch request, level.
- I_DSP_A  in  17  display fetch address.
- O_DSP_ACK  out  1  one-clock pulse; O_DSP_D valid that cycle.
- O_DSP_D  out  8  display read data.
- O_MEM_CE, O_MEM_WE  out  1 each  SRAM enables, active high.
- O_MEM_A  out  17  SRAM address.
- O_MEM_D  out  8  SRAM write data.
- I_MEM_Q  in  8  SRAM read data.

Behaviour:
- Address map: O_MEM_A = {region[2:0], off[13:0]}.
  - Regions: ATTR=0, TEXT=1, KANJI=2, B=3, R=4, G=5.
  - ATTR/TEXT/KANJI use off = {3'b000, I_A[10:0]}; GRAM uses I_A[13:0].
- CPU request: cpu_req = (any enabled CS) & (~I_RD_n | ~I_WR_n).
- O_WAIT_n = ~(cpu_req & ~cpu_done). This is combinational, so WAIT goes low the same cycle the request appears.
  - cpu_done is set on CPU access completion and cleared when cpu_req falls.
- FSM states: IDLE, DSP, CPU, CPU_NXT.
  - IDLE: if I_DSP_REQ and (no CPU pending or starve_cnt < STARVE_MAX), go to DSP; else if CPU pending and not cpu_done, go to CPU.
  - Simultaneous requests: display wins unless the starve limit is reached.
  - DSP: CE=1, WE=0, A=I_DSP_A latched on entry. After MEM_CYC clocks: O_DSP_D <= I_MEM_Q, O_DSP_ACK pulses, return to IDLE.
  - starve_cnt increments per display grant while CPU is pending; it clears on every CPU grant or when no CPU request is pending.
  - CPU: address, region mask, RD/WR and data are latched on entry. WE=1 for writes.
  - After MEM_CYC clocks: a read latches O_CPU_D and sets cpu_done. A write with further mask bits goes to CPU_NXT; otherwise it sets cpu_done.
  - CPU_NXT: clears the serviced mask bit, re-enters CPU with the next plane (order B, R, G), no idle cycle.
- Reads with multiple GRAM selects read only the lowest plane (B < R < G).
- Each CPU cycle is serviced once. A new access needs cpu_req to fall and rise again; a held strobe is not re-serviced.
- CE deasserts for at least one clock between accesses (the IDLE cycle).
- Reset values: O_WAIT_n=1, O_MEM_CE=0, O_MEM_WE=0, O_MEM_A=0, O_MEM_D=0, O_DSP_ACK=0, O_DSP_D=0, O_CPU_D=8'hFF. FSM=IDLE, starve_cnt=0, cpu_done=0.
- Reset mid-access aborts immediately (CE/WE drop asynchronously); a partial multi-plane write is not resumed.
- cpu_req falling mid-access (bus abort): the access completes and no cpu_done is left set.

Optional Feature:
- Macro NX1_DAM_MULTIWRITE_EN.
- Defined: a DAM write to multiple planes writes each selected plane sequentially through CPU_NXT, with WAIT held until the last plane finishes.
- Undefined: only the lowest selected plane is written; CPU_NXT is not built.

Decomposition:
- Shared package nx1_vram_pkg holds:
  - region code constants (REG_ATTR..REG_G);
  - FSM state encoding;
  - plane-priority order.
- One sub-module, nx1_vram_seq: the MEM_CYC cycle counter plus the CE/WE/sample strobe generator, reused by the DSP and CPU states.

Test Plan:
- Display-only read: I_DSP_REQ=1, I_DSP_A=17'h0C123, MEM_CYC=2, I_MEM_Q=8'h5A.
  - Expect CE high 2 clocks with A=0C123, WE=0.
  - Expect ACK on clock 3 with O_DSP_D=5A.
- CPU TEXT write: TEXT_CS=1, I_WR_n=0, I_A=14'h0123, I_D=8'h41.
  - Expect O_WAIT_n low same cycle, CE/WE 2 clocks at A=17'h04123, O_MEM_D=41.
  - Expect WAIT high afterwards until strobe release.
- Contention: DSP_REQ held high with CPU GRR read pending, STARVE_MAX=4.
  - Expect exactly 4 display grants, then a CPU grant at A={3'd4, I_A}; O_CPU_D = I_MEM_Q.
- DAM write, macro defined: GRR_CS=GRG_CS=1, I_WR_n=0, I_D=8'hFF.
  - Expect writes at region 4 then region 5 back-to-back; WAIT released only after the second.
  - Macro undefined: only the region 4 write.
- Reset mid-CPU access: assert I_RESET_n=0 during CE.
  - Expect CE/WE=0 and WAIT=1 immediately, O_CPU_D=FF; after release the FSM is in IDLE.
- KANJI_CS with def_X1TURBO=0 and I_RD_n=0 -> WAIT stays high, no CE.
